// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Owns the PC, handles stall, branch redirect/flush and misaligned-target faults.
module if_id_fetch_stage #(
  parameter int unsigned         PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP_INSN = 32'h00000013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [31:0]         if_id_instruction,
  output logic                if_id_valid,
  output logic                fetch_fault
);

  typedef enum logic [1:0] {StStart, StRun, StHalted} state_e;

  state_e state_q, state_d;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]         insn_q, insn_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;

  logic misaligned;
  logic do_redirect;
  logic do_fault;
  logic do_fetch;

  assign misaligned = (branch_target[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StStart;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStart:  state_d = (branch_taken && misaligned) ? StHalted : StRun;
      StRun:    state_d = (branch_taken && misaligned) ? StHalted : StRun;
      StHalted: state_d = StHalted;
      default:  state_d = StStart;
    endcase
  end

  // Output / datapath control: branch_taken beats stall; START never fetches.
  always_comb begin
    do_redirect = 1'b0;
    do_fault    = 1'b0;
    do_fetch    = 1'b0;
    unique case (state_q)
      StStart, StRun: begin
        if (branch_taken) begin
          do_fault    = misaligned;
          do_redirect = !misaligned;
        end else if (state_q == StRun && !stall) begin
          do_fetch = 1'b1;
        end
      end
      default: ;
    endcase

    pc_d       = pc_q;
    if_id_pc_d = if_id_pc_q;
    insn_d     = insn_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    if (do_redirect) begin
      pc_d    = branch_target;
      insn_d  = NOP_INSN;
      valid_d = 1'b0;
    end else if (do_fault) begin
      insn_d  = NOP_INSN;
      valid_d = 1'b0;
      fault_d = 1'b1;
    end else if (do_fetch) begin
      pc_d       = pc_q + PC_WIDTH'(4);
      if_id_pc_d = pc_q;
      insn_d     = imem_rdata;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_id_pc_q <= '0;
      insn_q     <= NOP_INSN;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_id_pc_q <= if_id_pc_d;
      insn_q     <= insn_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_addr         = pc_q;
  assign if_id_pc          = if_id_pc_q;
  assign if_id_instruction = insn_q;
  assign if_id_valid       = valid_q;
  assign fetch_fault       = fault_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed scenarios plus randomized
// stall/branch/reset traffic compared every cycle against a behavioural model.
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  if_id_fetch_stage #(
    .PC_WIDTH(64),
    .RESET_PC(64'h0),
    .NOP_INSN(32'h00000013)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .if_id_pc         (if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .fetch_fault      (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h00001263;
    if (a == 64'h4) return 32'h00500293;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5BD1E995;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the stage must hold after each edge.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_insn;
  logic        m_valid, m_fault;
  bit          m_started, m_halted;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 64'h0; m_ipc = 64'h0; m_insn = NOP; m_valid = 1'b0; m_fault = 1'b0;
      m_started = 1'b0; m_halted = 1'b0;
    end else if (!m_halted) begin
      if (branch_taken) begin
        m_insn = NOP; m_valid = 1'b0; m_started = 1'b1;
        if (branch_target % 4 != 0) begin
          m_fault = 1'b1; m_halted = 1'b1;
        end else begin
          m_pc = branch_target;
        end
      end else if (!m_started) begin
        m_started = 1'b1;
      end else if (!stall) begin
        m_ipc = m_pc; m_insn = mem_word(m_pc); m_valid = 1'b1; m_pc = m_pc + 64'd4;
      end
    end
  end

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instruction", {32'h0, if_id_instruction}, {32'h0, m_insn});
    chk("if_id_valid", {63'h0, if_id_valid}, {63'h0, m_valid});
    chk("fetch_fault", {63'h0, fetch_fault}, {63'h0, m_fault});
    chk("pc_aligned", {62'h0, imem_addr[1:0]}, 64'h0);
  end

  // Returns 2 time units after a rising edge; inputs change only here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) tick();
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_ipc", if_id_pc, 64'h0);
    chk("rst_insn", {32'h0, if_id_instruction}, {32'h0, NOP});
    chk("rst_valid", {63'h0, if_id_valid}, 64'h0);
    chk("rst_fault", {63'h0, fetch_fault}, 64'h0);

    // 1: START then two fetches
    reset = 1'b0;
    tick();
    chk("start_valid", {63'h0, if_id_valid}, 64'h0);
    chk("start_addr", imem_addr, 64'h0);
    tick();
    chk("f1_insn", {32'h0, if_id_instruction}, 64'h00001263);
    chk("f1_ipc", if_id_pc, 64'h0);
    chk("f1_valid", {63'h0, if_id_valid}, 64'h1);
    chk("f1_addr", imem_addr, 64'h4);
    tick();
    chk("f2_insn", {32'h0, if_id_instruction}, 64'h00500293);
    chk("f2_ipc", if_id_pc, 64'h4);

    // 2: stall for three cycles at pc=8
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_addr", imem_addr, 64'h8);
      chk("stall_ipc", if_id_pc, 64'h4);
      chk("stall_valid", {63'h0, if_id_valid}, 64'h1);
    end
    stall = 1'b0;
    tick();
    chk("post_stall_ipc", if_id_pc, 64'h8);
    chk("post_stall_insn", {32'h0, if_id_instruction}, {32'h0, mem_word(64'h8)});
    tick();

    // 3: redirect with simultaneous stall at pc=16
    chk("pre_br_addr", imem_addr, 64'h10);
    branch_taken = 1'b1; branch_target = 64'h40; stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    chk("br_addr", imem_addr, 64'h40);
    chk("br_insn", {32'h0, if_id_instruction}, {32'h0, NOP});
    chk("br_valid", {63'h0, if_id_valid}, 64'h0);
    tick();
    chk("br_fetch_ipc", if_id_pc, 64'h40);
    chk("br_fetch_insn", {32'h0, if_id_instruction}, {32'h0, mem_word(64'h40)});

    // 4: misaligned redirect halts
    branch_taken = 1'b1; branch_target = 64'h42;
    tick();
    chk("fault", {63'h0, fetch_fault}, 64'h1);
    chk("fault_valid", {63'h0, if_id_valid}, 64'h0);
    chk("fault_addr", imem_addr, 64'h44);
    for (int i = 0; i < 8; i++) begin
      stall = 1'($urandom); branch_taken = 1'($urandom);
      branch_target = {$urandom, $urandom} & ~64'h3;
      tick();
      chk("halt_addr", imem_addr, 64'h44);
      chk("halt_valid", {63'h0, if_id_valid}, 64'h0);
    end
    branch_taken = 1'b0; stall = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_fault_clr", {63'h0, fetch_fault}, 64'h0);
    chk("async_addr", imem_addr, 64'h0);
    tick();
    reset = 1'b0;

    // 5: redirect to top of address space, then wrap
    tick();
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("wrap_ipc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem_addr, 64'h0);

    // 6: async reset mid-cycle at pc=0x20
    repeat (8) tick();
    chk("pre_rst_addr", imem_addr, 64'h20);
    chk("pre_rst_valid", {63'h0, if_id_valid}, 64'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {63'h0, if_id_valid}, 64'h0);
    chk("mid_rst_insn", {32'h0, if_id_instruction}, {32'h0, NOP});
    chk("mid_rst_addr", imem_addr, 64'h0);
    tick();
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      stall        = ($urandom_range(0, 99) < 30);
      branch_taken = (r < 10);
      branch_target = {$urandom, $urandom};
      if ($urandom_range(0, 9) != 0) branch_target[1:0] = 2'b00;
      if ($urandom_range(0, 149) == 0) begin
        #($urandom_range(0, 6)) reset = 1'b1;
      end else if (reset || (m_halted && $urandom_range(0, 3) == 0)) begin
        reset = m_halted;
      end
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
